// File: rtl/pipe_stage_elastic.sv
// Purpose: elastic inter-stage pipeline register with a 2-entry skid buffer, flush bubble and starvation counter.
// Latency: 1 cycle from acceptance to out_valid; sustains one entry per cycle.
// Backpressure: in_ready depends only on the skid valid bit and flush, never on out_ready.
module pipe_stage_elastic #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 164,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter logic [DATA_W-1:0] KEEP_MASK   = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  starve_cnt
);

    logic              head_valid;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              acc;
    logic              pop;

    // Handshake decode; the ready path sees only registered state plus flush.
    always_comb begin
        in_ready  = !skid_valid && !flush;
        acc       = in_valid && in_ready;
        out_valid = head_valid;
        pop       = head_valid && out_ready;
        out_ctrl  = head_ctrl;
        out_data  = head_data;
        occupancy = {1'b0, head_valid} + {1'b0, skid_valid};
    end

    // Head/skid storage: head feeds the outputs directly and holds bubble values when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            head_ctrl  <= BUBBLE_CTRL;
            head_data  <= BUBBLE_DATA;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Flush drops both entries; selected data bits (e.g. PC+4) ride into the bubble.
            head_valid <= 1'b0;
            head_ctrl  <= BUBBLE_CTRL;
            head_data  <= (BUBBLE_DATA & ~KEEP_MASK) | (in_data & KEEP_MASK);
            skid_valid <= 1'b0;
        end else if (!head_valid || pop) begin
            if (skid_valid) begin
                // Skid drains into head; no acceptance is possible while skid is full.
                head_valid <= 1'b1;
                head_ctrl  <= skid_ctrl;
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (acc) begin
                head_valid <= 1'b1;
                head_ctrl  <= in_ctrl;
                head_data  <= in_data;
            end else begin
                head_valid <= 1'b0;
                head_ctrl  <= BUBBLE_CTRL;
                head_data  <= BUBBLE_DATA;
            end
        end else if (acc) begin
            // Head stalled: park the new entry in the skid register.
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end

    // Starvation counter: downstream ready but nothing to give; saturates, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (out_ready && !head_valid && (starve_cnt != {CNT_W{1'b1}})) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: reset/idle, streaming, backpressure, flush, saturation, async reset.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven right after sampling.
// A 4-bit starvation counter is used so saturation is reached quickly.
module tb_pipe_stage_elastic;

    localparam int          CTRL_W = 16;
    localparam int          DATA_W = 72;
    localparam int          CNT_W  = 4;
    localparam logic [15:0] BC     = 16'h5140;
    localparam logic [71:0] BD     = 72'h3C_1234_5678_0000_00C3;
    localparam logic [71:0] KM     = 72'h00_FFFF_FFFF_0000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  starve_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_elastic #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_CTRL(BC),
        .BUBBLE_DATA(BD), .KEEP_MASK(KM), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        // Reset state
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_out_ctrl",  72'(out_ctrl), 72'(BC));
        chk("rst_out_data",  out_data, BD);
        chk("rst_in_ready",  72'(in_ready), 72'd1);
        chk("rst_occupancy", 72'(occupancy), 72'd0);
        chk("rst_starve",    72'(starve_cnt), 72'd0);
        // Idle starvation counting then saturation
        step();
        chk("starve_1", 72'(starve_cnt), 72'd1);
        step();
        chk("starve_2", 72'(starve_cnt), 72'd2);
        chk("idle_ctrl", 72'(out_ctrl), 72'(BC));
        for (int i = 0; i < 18; i++) step();
        chk("starve_sat", 72'(starve_cnt), 72'hF);

        // Streaming 4 entries back to back
        in_valid = 1'b1; in_data = 72'd1; in_ctrl = 16'h0011;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("stream_valid_%0d", i), 72'(out_valid), 72'd1);
            chk($sformatf("stream_data_%0d", i), out_data, 72'(i));
            chk($sformatf("stream_rdy_%0d", i), 72'(in_ready), 72'd1);
            chk($sformatf("stream_occ_%0d", i), 72'(occupancy), 72'd1);
            in_data = 72'(i + 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_valid", 72'(out_valid), 72'd0);
        chk("stream_drain_data", out_data, BD);
        chk("starve_held", 72'(starve_cnt), 72'hF);

        // Backpressure: A to head, B to skid, C blocked
        out_ready = 1'b0; in_valid = 1'b1; in_data = 72'hA; in_ctrl = 16'h000A;
        step();
        chk("bp_occ_1", 72'(occupancy), 72'd1);
        in_data = 72'hB; in_ctrl = 16'h000B;
        step();
        chk("bp_occ_2", 72'(occupancy), 72'd2);
        chk("bp_rdy_0", 72'(in_ready), 72'd0);
        chk("bp_head_a", out_data, 72'hA);
        in_data = 72'hC; in_ctrl = 16'h000C;
        step();
        chk("bp_hold_a", out_data, 72'hA);
        chk("bp_hold_ctrl", 72'(out_ctrl), 72'hA);
        chk("bp_hold_occ", 72'(occupancy), 72'd2);
        out_ready = 1'b1;
        step();
        chk("bp_emit_b", out_data, 72'hB);
        chk("bp_emit_b_occ", 72'(occupancy), 72'd1);
        chk("bp_rdy_1", 72'(in_ready), 72'd1);
        step();
        chk("bp_emit_c", out_data, 72'hC);
        chk("bp_emit_c_valid", 72'(out_valid), 72'd1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 72'(out_valid), 72'd0);

        // Flush with two entries held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 72'h1; in_ctrl = 16'h0001;
        step();
        in_data = 72'h2; in_ctrl = 16'h0002;
        step();
        chk("fl_pre_occ", 72'(occupancy), 72'd2);
        flush = 1'b1; in_data = 72'hFF_0040_0010_FFFF_FFFF;
        #1;
        chk("fl_rdy", 72'(in_ready), 72'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 72'(occupancy), 72'd0);
        chk("fl_valid", 72'(out_valid), 72'd0);
        chk("fl_ctrl", 72'(out_ctrl), 72'(BC));
        chk("fl_data", out_data, 72'h3C_0040_0010_0000_00C3);
        step();
        chk("fl_after_data", out_data, BD);

        // Async reset with two entries held
        in_valid = 1'b1; in_data = 72'h5; in_ctrl = 16'h0005;
        step();
        in_data = 72'h6; in_ctrl = 16'h0006;
        step();
        chk("ar_pre_occ", 72'(occupancy), 72'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_occ", 72'(occupancy), 72'd0);
        chk("ar_valid", 72'(out_valid), 72'd0);
        chk("ar_ctrl", 72'(out_ctrl), 72'(BC));
        chk("ar_data", out_data, BD);
        chk("ar_starve", 72'(starve_cnt), 72'd0);
        chk("ar_rdy", 72'(in_ready), 72'd1);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("ar_starve_1", 72'(starve_cnt), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
